spi_link: RTL

- Byte-level SPI target (mode 0, MSB first) sitting directly upstream of the command decoder.
- Oversamples the host's SPI pins in the system clock domain.
- Pushes received bytes into an RX FIFO exposed as rd_data/rd_valid/rd_ready.
- Requests response bytes via wr_valid/wr_data/wr_ready and pulses start at the beginning of every transaction.

---
 rtl/spi_link_if.sv | 24 ++
 rtl/spi_link.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/spi_link_if.sv
// spi_link consumer-side bus: RX FIFO read port, TX response request and
// transaction status. The link drives through 'master', the command decoder
// side connects through 'slave'.
interface spi_link_if;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       rd_ready;
    logic [7:0] wr_data;
    logic       wr_valid;
    logic       wr_ready;
    logic       start;
    logic       overflow;
    logic       underrun;

    modport master (
        output rd_data, rd_valid, wr_valid, start, overflow, underrun,
        input  rd_ready, wr_data, wr_ready
    );

    modport slave (
        input  rd_data, rd_valid, wr_valid, start, overflow, underrun,
        output rd_ready, wr_data, wr_ready
    );
endinterface

// File: rtl/spi_link.sv
// spi_link: byte-level SPI target (mode 0, MSB first), oversampled in the clk
// domain. Received bytes go into a show-ahead RX FIFO; response bytes come
// through a one-entry TX holding register. Optional macro SPI_LINK_STATS_EN
// adds rx_count / drop_count statistics outputs.
module spi_link #(
    parameter int         FIFO_DEPTH = 16,
    parameter logic [7:0] FILL_BYTE  = 8'hFF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        spi_sck,
    input  logic        spi_cs_n,
    input  logic        spi_mosi,
    output logic        spi_miso,
    spi_link_if.master  bus
`ifdef SPI_LINK_STATS_EN
    ,
    output logic [15:0] rx_count,
    output logic [7:0]  drop_count
`endif
);
    localparam int         AW      = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] DEPTH_L = FIFO_DEPTH[AW:0];

    typedef enum logic {IDLE, XFER} state_t;

    // [0]/[1] synchroniser stages, [2] history for edge detection
    logic [2:0] sck_sr, cs_sr;
    logic [1:0] mosi_sr;

    logic       sck_rise, sck_fall, cs_fall, cs_rise, cs_act;
    logic       rise_x, fall_x;
    state_t     state, state_nxt;
    logic       start;

    logic [2:0] bit_cnt;
    logic [6:0] rx_sh;
    logic       push_req;
    logic [7:0] push_byte;
    logic       byte_end;
    logic [7:0] tx_sh;
    logic [7:0] hold;
    logic       hold_full;
    logic       req_all;
    logic       underrun;
    logic       wr_valid;

    logic [7:0]  mem [FIFO_DEPTH];
    logic [AW:0] wptr, rptr, count;
    logic        full, empty, pop, wr_en, drop;
    logic        overflow;

    // Bring the asynchronous SPI pins into the clk domain
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sck_sr  <= 3'b000;
            cs_sr   <= 3'b111;
            mosi_sr <= 2'b00;
        end else begin
            sck_sr  <= {sck_sr[1:0], spi_sck};
            cs_sr   <= {cs_sr[1:0], spi_cs_n};
            mosi_sr <= {mosi_sr[0], spi_mosi};
        end
    end

    assign sck_rise = sck_sr[1] & ~sck_sr[2];
    assign sck_fall = ~sck_sr[1] & sck_sr[2];
    assign cs_fall  = ~cs_sr[1] & cs_sr[2];
    assign cs_rise  = cs_sr[1] & ~cs_sr[2];
    assign cs_act   = ~cs_sr[1];

    // sck edges only count inside a selected transaction
    assign rise_x = sck_rise & (state == XFER) & ~cs_rise;
    assign fall_x = sck_fall & (state == XFER) & ~cs_rise;

    // Transaction state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    // Transaction next state; start fires on the select edge
    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        case (state)
            IDLE: if (cs_fall) begin
                state_nxt = XFER;
                start     = 1'b1;
            end
            XFER: if (cs_rise) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign wr_valid = ~hold_full & cs_act;

    // Bit counter, RX assembly, TX shifter, holding register and underrun.
    // req_all tracks whether the consumer has been asked for a byte for the
    // whole byte now finishing; it re-arms at every byte boundary.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bit_cnt   <= '0;
            rx_sh     <= '0;
            push_req  <= 1'b0;
            push_byte <= '0;
            byte_end  <= 1'b0;
            tx_sh     <= FILL_BYTE;
            hold      <= '0;
            hold_full <= 1'b0;
            req_all   <= 1'b0;
            underrun  <= 1'b0;
        end else if (start) begin
            bit_cnt   <= '0;
            push_req  <= 1'b0;
            byte_end  <= 1'b0;
            tx_sh     <= FILL_BYTE;
            hold_full <= 1'b0;
            req_all   <= 1'b1;
            underrun  <= 1'b0;
        end else begin
            push_req <= 1'b0;
            if (cs_rise) begin
                bit_cnt  <= '0;
                byte_end <= 1'b0;
            end else if (rise_x) begin
                rx_sh   <= {rx_sh[5:0], mosi_sr[1]};
                bit_cnt <= bit_cnt + 3'd1;
                if (bit_cnt == 3'd7) begin
                    push_req  <= 1'b1;
                    push_byte <= {rx_sh, mosi_sr[1]};
                    byte_end  <= 1'b1;
                end
            end

            if (fall_x) begin
                if (byte_end) begin
                    byte_end <= 1'b0;
                    if (hold_full) begin
                        tx_sh     <= hold;
                        hold_full <= 1'b0;
                    end else begin
                        tx_sh <= FILL_BYTE;
                        if (req_all && wr_valid) underrun <= 1'b1;
                    end
                end else begin
                    tx_sh <= {tx_sh[6:0], 1'b1};
                end
            end

            // Only an empty holding register accepts; a full one keeps its byte
            if (wr_valid && bus.wr_ready) begin
                hold      <= bus.wr_data;
                hold_full <= 1'b1;
            end

            if (fall_x && byte_end) req_all <= 1'b1;
            else if (!wr_valid)     req_all <= 1'b0;
        end
    end

    assign spi_miso = (state == XFER) ? tx_sh[7] : 1'b1;

    assign count = wptr - rptr;
    assign full  = (count == DEPTH_L);
    assign empty = (wptr == rptr);
    assign pop   = bus.rd_ready & ~empty & ~start;
    assign wr_en = push_req & (~full | pop) & ~start;
    assign drop  = push_req & full & ~pop & ~start;

    // FIFO storage, no reset needed: reads are gated by rd_valid
    always_ff @(posedge clk) begin
        if (wr_en) mem[wptr[AW-1:0]] <= push_byte;
    end

    // FIFO pointers and overflow flag; start flushes
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wptr     <= '0;
            rptr     <= '0;
            overflow <= 1'b0;
        end else if (start) begin
            wptr     <= '0;
            rptr     <= '0;
            overflow <= 1'b0;
        end else begin
            if (pop)   rptr     <= rptr + 1'b1;
            if (wr_en) wptr     <= wptr + 1'b1;
            if (drop)  overflow <= 1'b1;
        end
    end

`ifdef SPI_LINK_STATS_EN
    // Per-transaction pushed and dropped byte counts
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_count   <= '0;
            drop_count <= '0;
        end else if (start) begin
            rx_count   <= '0;
            drop_count <= '0;
        end else begin
            if (wr_en) rx_count <= rx_count + 16'd1;
            if (drop && drop_count != 8'hFF) drop_count <= drop_count + 8'd1;
        end
    end
`endif

    assign bus.rd_valid = ~empty;
    assign bus.rd_data  = empty ? 8'h00 : mem[rptr[AW-1:0]];
    assign bus.wr_valid = wr_valid;
    assign bus.start    = start;
    assign bus.overflow = overflow;
    assign bus.underrun = underrun;
endmodule
